// File: rtl/lock_pkg.sv
// lock_pkg: shared FSM state encoding and debounce default for the lock front-end
package lock_pkg;
   typedef enum logic {ST_IDLE = 1'b0, ST_HELD = 1'b1} state_t;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
endpackage

// File: rtl/debounce_filter.sv
// debounce_filter: 2-FF synchroniser plus stability counter for one raw button
module debounce_filter
   import lock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   logic s1, s2;
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         dout <= 1'b0;
         cnt  <= '0;
      end else begin
         s1 <= din;
         s2 <= s1;
         if (s2 == dout) cnt <= '0;
         else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            dout <= s2;
            cnt  <= '0;
         end else cnt <= cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: debounced keypad to one/zero/unlatch strobes for the lock FSM
module key_conditioner
   import lock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_one,
   input  logic raw_zero,
   output logic one,
   output logic zero,
   output logic unlatch,
   output logic busy
);
   logic db_one, db_zero, one_n, zero_n, unlatch_n;
   state_t state, state_n;
   debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_one (
      .clk(clk), .reset(reset), .din(raw_one), .dout(db_one)
   );
   debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_zero (
      .clk(clk), .reset(reset), .din(raw_zero), .dout(db_zero)
   );
   // any held key keeps us in HELD; only the IDLE->HELD edge strobes a key
   always_comb begin
      state_n   = (db_one || db_zero) ? ST_HELD : ST_IDLE;
      one_n     = (state == ST_IDLE) && db_one;
      zero_n    = (state == ST_IDLE) && !db_one && db_zero;
      unlatch_n = (state == ST_HELD) && !db_one && !db_zero;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= ST_IDLE;
         one     <= 1'b0;
         zero    <= 1'b0;
         unlatch <= 1'b0;
      end else begin
         state   <= state_n;
         one     <= one_n;
         zero    <= zero_n;
         unlatch <= unlatch_n;
      end
   end
   assign busy = (state == ST_HELD);
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed scenarios plus random bouncing against a window-based reference model
module tb_key_conditioner;
   localparam int D = 4;
   logic clk = 1'b0, reset = 1'b0, raw_one = 1'b0, raw_zero = 1'b0;
   logic one, zero, unlatch, busy;
   int errors = 0, checks = 0;
   int n_one, n_zero, n_unl, n_busy, lat;
   bit sy[2][$];
   bit win[2][$];
   bit db[2];
   bit m_held, m_one, m_zero, m_unl;

   key_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .reset(reset), .raw_one(raw_one), .raw_zero(raw_zero),
      .one(one), .zero(zero), .unlatch(unlatch), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic chk_n(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         sy[k].delete();
         sy[k].push_back(1'b0);
         sy[k].push_back(1'b0);
         win[k].delete();
         db[k] = 1'b0;
      end
      m_held = 0; m_one = 0; m_zero = 0; m_unl = 0;
   endtask

   // One clock: advance the model on the values present at the edge, then compare.
   task automatic step();
      bit rw[2];
      bit rst, s2, all_diff;
      rw[0] = raw_one;
      rw[1] = raw_zero;
      rst = reset;
      @(posedge clk);
      if (!rst) model_clear();
      else begin
         m_one  = !m_held && db[0];
         m_zero = !m_held && !db[0] && db[1];
         m_unl  = m_held && !db[0] && !db[1];
         m_held = db[0] || db[1];
         for (int k = 0; k < 2; k++) begin
            s2 = sy[k][0];
            win[k].push_back(s2);
            if (win[k].size() > D) void'(win[k].pop_front());
            all_diff = (win[k].size() == D);
            foreach (win[k][i]) if (win[k][i] == db[k]) all_diff = 0;
            if (all_diff) begin
               db[k] = s2;
               win[k].delete();
            end
            sy[k].push_back(rw[k]);
            void'(sy[k].pop_front());
         end
      end
      #1;
      chk("one", one, m_one);
      chk("zero", zero, m_zero);
      chk("unlatch", unlatch, m_unl);
      chk("busy", busy, m_held);
      chk("exclusive", (32'(one) + 32'(zero) + 32'(unlatch)) > 1, 1'b0);
      n_one  += int'(one === 1'b1);
      n_zero += int'(zero === 1'b1);
      n_unl  += int'(unlatch === 1'b1);
      n_busy += int'(busy === 1'b1);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic clr();
      n_one = 0; n_zero = 0; n_unl = 0; n_busy = 0;
   endtask

   // edges counted from the first edge that samples the new input (that edge = 1)
   task automatic wait_one(output int edges);
      edges = 0;
      do begin
         step();
         edges++;
      end while (one !== 1'b1 && edges <= 40);
   endtask

   task automatic wait_unl(output int edges);
      edges = 0;
      do begin
         step();
         edges++;
      end while (unlatch !== 1'b1 && edges <= 40);
   endtask

   initial begin
      model_clear();
      clr();
      reset = 1'b0;
      run(3);
      reset = 1'b1;
      run(5);
      // 1: clean press and release
      clr();
      raw_one = 1'b1;
      wait_one(lat);
      chk_n("t1_press_latency", lat, 7);
      run(30 - lat);
      chk("t1_busy_held", busy, 1'b1);
      raw_one = 1'b0;
      wait_unl(lat);
      chk_n("t1_release_latency", lat, 7);
      run(3);
      chk_n("t1_one_count", n_one, 1);
      chk_n("t1_zero_count", n_zero, 0);
      chk_n("t1_unlatch_count", n_unl, 1);
      // 2: bouncing then settling high
      clr();
      for (int i = 0; i < 10; i++) begin
         raw_one = ~raw_one;
         run(2);
      end
      chk_n("t2_no_strobe_bounce", n_one + n_busy, 0);
      raw_one = 1'b1;
      wait_one(lat);
      chk_n("t2_settle_latency", lat, 7);
      raw_one = 1'b0;
      run(15);
      chk_n("t2_one_count", n_one, 1);
      // 3: short glitch on zero
      clr();
      raw_zero = 1'b1;
      run(3);
      raw_zero = 1'b0;
      run(15);
      chk_n("t3_zero_count", n_zero, 0);
      chk_n("t3_busy_cycles", n_busy, 0);
      chk_n("t3_unlatch_count", n_unl, 0);
      // 4: simultaneous press, one has priority
      clr();
      raw_one = 1'b1;
      raw_zero = 1'b1;
      run(30);
      raw_one = 1'b0;
      raw_zero = 1'b0;
      run(15);
      chk_n("t4_one_count", n_one, 1);
      chk_n("t4_zero_count", n_zero, 0);
      chk_n("t4_unlatch_count", n_unl, 1);
      // 5: overlapping presses
      clr();
      raw_one = 1'b1;
      wait_one(lat);
      chk_n("t5_press_latency", lat, 7);
      raw_zero = 1'b1;
      run(15);
      raw_one = 1'b0;
      run(15);
      chk_n("t5_no_early_unlatch", n_unl, 0);
      chk("t5_still_busy", busy, 1'b1);
      raw_zero = 1'b0;
      wait_unl(lat);
      chk_n("t5_unlatch_latency", lat, 7);
      chk_n("t5_zero_count", n_zero, 0);
      // 6: reset while held
      clr();
      raw_one = 1'b1;
      wait_one(lat);
      run(3);
      reset = 1'b0;
      step();
      chk("t6_busy_in_reset", busy, 1'b0);
      chk("t6_one_in_reset", one, 1'b0);
      step();
      reset = 1'b1;
      wait_one(lat);
      chk_n("t6_post_reset_latency", lat, 7);
      raw_one = 1'b0;
      run(15);
      // random bouncing with occasional reset
      for (int seg = 0; seg < 250; seg++) begin
         raw_one = 1'($urandom_range(0, 1));
         raw_zero = 1'($urandom_range(0, 1));
         reset = ($urandom_range(0, 30) != 0);
         run($urandom_range(1, 12));
         reset = 1'b1;
      end
      raw_one = 1'b0;
      raw_zero = 1'b0;
      run(20);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
